// File: rtl/if_stage_pkg.sv
// Shared widths, constants and state encoding for the byte-serial instruction fetch stage.
package if_stage_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int STALL_W     = 6;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        TRUE_V    = 1'b1;
    localparam logic        FALSE_V   = 1'b0;

    // Byte counters run 0..4; 4 means all four bytes of the word are covered.
    typedef logic [2:0] cnt_t;
    localparam cnt_t CNT_FULL = 3'd4;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_DONE  = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: assembles a 32-bit instruction from four byte-wide memory
// transactions, presents it for one cycle (or while stalled), and handles EX redirects.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall_state,
    input  logic                   ex_be_i,
    input  logic [INST_ADDR_W-1:0] ex_target_i,
    input  logic                   mem_grant_i,
    input  logic                   mem_valid_i,
    input  logic [7:0]             mem_data_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   if_stall_req_o
);

    if_state_e              state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    cnt_t                   issue_cnt_q, issue_cnt_d;
    cnt_t                   recv_cnt_q, recv_cnt_d;
    logic [INST_W-1:0]      inst_q, inst_d;

    logic                   req;
    logic                   present;
    logic [INST_ADDR_W-1:0] fetch_addr;
    logic                   unused_ok;

    assign fetch_addr = pc_q + {{(INST_ADDR_W-3){1'b0}}, issue_cnt_q};
    assign unused_ok  = ^{stall_state[STALL_W-1:2], stall_state[0], ex_target_i[1:0]};

    always_comb begin
        // NOTE: every variable gets a default here so no path can leave it unassigned (no latches).
        state_d     = state_q;
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        inst_d      = inst_q;
        req         = FALSE_V;
        present     = FALSE_V;

        unique case (state_q)
            IF_FETCH: begin
                if (issue_cnt_q < CNT_FULL) begin
                    req = TRUE_V;
                    if (mem_grant_i) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                end
                // A byte only counts when a granted request is still waiting for its data.
                if (mem_valid_i && (recv_cnt_q < issue_cnt_q)) begin
                    inst_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_data_i;
                    recv_cnt_d = recv_cnt_q + 3'd1;
                end
                if (recv_cnt_d == CNT_FULL) begin
                    state_d = IF_DONE;
                end
            end
            IF_DONE: begin
                present = TRUE_V;
                if (!stall_state[1]) begin
                    pc_d        = pc_q + 32'd4;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    inst_d      = ZERO_WORD;
                    state_d     = IF_FETCH;
                end
            end
            IF_FLUSH: begin
                state_d = IF_FETCH;
            end
            default: begin
                state_d = IF_FETCH;
            end
        endcase

        // Redirect beats stall and every state; the in-flight byte and held word are dropped.
        if (ex_be_i) begin
            pc_d        = {ex_target_i[INST_ADDR_W-1:2], 2'b00};
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            inst_d      = ZERO_WORD;
            state_d     = IF_FLUSH;
            req         = FALSE_V;
            present     = FALSE_V;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q     <= IF_FETCH;
            pc_q        <= ZERO_WORD;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            inst_q      <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            inst_q      <= inst_d;
        end
    end

    // Outputs are qualified by reset so nothing is requested or presented while it is held.
    assign mem_req_o      = rst & req;
    assign mem_addr_o     = (rst & req) ? fetch_addr : ZERO_WORD;
    assign if_stall_req_o = rst & (state_q != IF_DONE);
    assign if_pc          = (rst & present) ? pc_q : ZERO_WORD;
    assign if_inst        = (rst & present) ? inst_q : ZERO_WORD;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a cycle vector table, directed multi-cycle sequences,
// and a randomized run checked against a transaction-level fetch model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_state;
    logic        ex_be_i;
    logic [31:0] ex_target_i;
    logic        mem_grant_i;
    logic        mem_valid_i;
    logic [7:0]  mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall_req_o;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_state    (stall_state),
        .ex_be_i        (ex_be_i),
        .ex_target_i    (ex_target_i),
        .mem_grant_i    (mem_grant_i),
        .mem_valid_i    (mem_valid_i),
        .mem_data_i     (mem_data_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_stall_req_o (if_stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory responder state: a request granted this cycle returns its byte next cycle.
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    typedef struct {
        logic        g;
        logic        v;
        logic [7:0]  d;
        logic        be;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 8'h13;
            32'h0000_0001: return 8'h05;
            32'h0000_0002: return 8'h10;
            32'h0000_0003: return 8'h00;
            default:       return {a[2:0], a[7:3]} ^ a[31:24] ^ a[15:8] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    function automatic vec_t mk(input logic g, input logic v, input logic [7:0] d,
                                input logic be, input logic [31:0] tgt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_sreq, input logic [31:0] e_pc,
                                input logic [31:0] e_inst);
        vec_t r;
        r.g = g; r.v = v; r.d = d; r.be = be; r.tgt = tgt;
        r.e_req = e_req; r.e_addr = e_addr; r.e_sreq = e_sreq; r.e_pc = e_pc; r.e_inst = e_inst;
        return r;
    endfunction

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
    task automatic apply(input logic g, input logic [5:0] st, input logic be,
                         input logic [31:0] tgt, input logic spur);
        mem_grant_i = g;
        stall_state = st;
        ex_be_i     = be;
        ex_target_i = tgt;
        if (pend) begin
            mem_valid_i = 1'b1;
            mem_data_i  = mem_byte(pend_addr);
        end else if (spur) begin
            mem_valid_i = 1'b1;
            mem_data_i  = 8'($urandom);
        end else begin
            mem_valid_i = 1'b0;
            mem_data_i  = 8'h00;
        end
        #1;
    endtask

    task automatic advance();
        pend      = mem_req_o && mem_grant_i && rst;
        pend_addr = mem_addr_o;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
            advance();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
            check("reset_req", 32'(mem_req_o), 32'd0);
            check("reset_sreq", 32'(if_stall_req_o), 32'd0);
            check("reset_pc", if_pc, 32'd0);
            check("reset_inst", if_inst, 32'd0);
            advance();
        end
        rst  = 1'b1;
        pend = 1'b0;
    endtask

    task automatic check_present(input string name, input logic [31:0] pc, input logic [31:0] inst);
        check({name, "_sreq"}, 32'(if_stall_req_o), 32'd0);
        check({name, "_pc"}, if_pc, pc);
        check({name, "_inst"}, if_inst, inst);
    endtask

    task automatic check_req(input string name, input logic [31:0] addr);
        check({name, "_req"}, 32'(mem_req_o), 32'd1);
        check({name, "_addr"}, mem_addr_o, addr);
    endtask

    logic        g;
    logic [5:0]  st;
    logic        spur;
    logic [31:0] m_pc;
    int          m_k;
    int          due;
    logic        pres;
    int          npres;

    initial begin
        rst = 1'b0; stall_state = '0; ex_be_i = 1'b0; ex_target_i = '0;
        mem_grant_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
        @(negedge clk);

        // Cycle table: basic fetch of 0x00100513, then a redirect to 0x103 after two bytes.
        vecs[0]  = mk(1, 0, 8'h00, 0, 0,        1, 32'h0,   1, 32'h0,   32'h0);
        vecs[1]  = mk(1, 1, 8'h13, 0, 0,        1, 32'h1,   1, 32'h0,   32'h0);
        vecs[2]  = mk(1, 1, 8'h05, 0, 0,        1, 32'h2,   1, 32'h0,   32'h0);
        vecs[3]  = mk(1, 1, 8'h10, 0, 0,        1, 32'h3,   1, 32'h0,   32'h0);
        vecs[4]  = mk(1, 1, 8'h00, 0, 0,        0, 32'h0,   1, 32'h0,   32'h0);
        vecs[5]  = mk(1, 0, 8'h00, 0, 0,        0, 32'h0,   0, 32'h0,   32'h0010_0513);
        vecs[6]  = mk(1, 0, 8'h00, 0, 0,        1, 32'h4,   1, 32'h0,   32'h0);
        vecs[7]  = mk(1, 1, 8'h11, 0, 0,        1, 32'h5,   1, 32'h0,   32'h0);
        vecs[8]  = mk(1, 1, 8'h22, 0, 0,        1, 32'h6,   1, 32'h0,   32'h0);
        vecs[9]  = mk(1, 1, 8'hAA, 1, 32'h103,  0, 32'h0,   1, 32'h0,   32'h0);
        vecs[10] = mk(1, 1, 8'hEE, 0, 0,        0, 32'h0,   1, 32'h0,   32'h0);
        vecs[11] = mk(1, 0, 8'h00, 0, 0,        1, 32'h100, 1, 32'h0,   32'h0);
        vecs[12] = mk(1, 1, 8'h93, 0, 0,        1, 32'h101, 1, 32'h0,   32'h0);
        vecs[13] = mk(1, 1, 8'h00, 0, 0,        1, 32'h102, 1, 32'h0,   32'h0);
        vecs[14] = mk(1, 1, 8'h10, 0, 0,        1, 32'h103, 1, 32'h0,   32'h0);
        vecs[15] = mk(1, 1, 8'h00, 0, 0,        0, 32'h0,   1, 32'h0,   32'h0);
        vecs[16] = mk(1, 0, 8'h00, 0, 0,        0, 32'h0,   0, 32'h100, 32'h0010_0093);
        vecs[17] = mk(1, 0, 8'h00, 0, 0,        1, 32'h104, 1, 32'h0,   32'h0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            mem_grant_i = vecs[i].g;
            mem_valid_i = vecs[i].v;
            mem_data_i  = vecs[i].d;
            ex_be_i     = vecs[i].be;
            ex_target_i = vecs[i].tgt;
            stall_state = 6'd0;
            #1;
            check($sformatf("vec%0d_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
            if (vecs[i].e_req) check($sformatf("vec%0d_addr", i), mem_addr_o, vecs[i].e_addr);
            check($sformatf("vec%0d_sreq", i), 32'(if_stall_req_o), 32'(vecs[i].e_sreq));
            check($sformatf("vec%0d_pc", i), if_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_inst", i), if_inst, vecs[i].e_inst);
            @(negedge clk);
        end
        pend = 1'b0;

        // Grant withheld for three cycles after the second request.
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            g = !(c >= 3 && c <= 5);
            apply(g, 6'd0, 1'b0, 32'd0, 1'b0);
            if (c <= 7) check_req($sformatf("gap_c%0d", c),
                                  (c <= 2) ? 32'(c - 1) : ((c <= 5) ? 32'd2 : 32'(c - 4)));
            if (c == 8) begin
                check("gap_wait_req", 32'(mem_req_o), 32'd0);
                check("gap_wait_sreq", 32'(if_stall_req_o), 32'd1);
            end
            if (c == 9) check_present("gap_done", 32'h0, 32'h0010_0513);
            if (c == 10) check_req("gap_next", 32'h4);
            advance();
        end

        // Held in DONE by stall for four cycles.
        do_reset();
        idle(5);
        for (int c = 6; c <= 9; c++) begin
            apply(1'b1, 6'b000010, 1'b0, 32'd0, 1'b0);
            check_present($sformatf("hold_c%0d", c), 32'h0, 32'h0010_0513);
            check("hold_req", 32'(mem_req_o), 32'd0);
            advance();
        end
        apply(1'b1, 6'b000000, 1'b0, 32'd0, 1'b0);
        check_present("hold_release", 32'h0, 32'h0010_0513);
        advance();
        apply(1'b1, 6'b000000, 1'b0, 32'd0, 1'b0);
        check_req("hold_next", 32'h4);
        advance();

        // Redirect coincident with a stalled DONE.
        do_reset();
        idle(5);
        apply(1'b1, 6'b000010, 1'b1, 32'h200, 1'b0);
        check("redir_done_req", 32'(mem_req_o), 32'd0);
        check("redir_done_pc", if_pc, 32'h0);
        check("redir_done_inst", if_inst, 32'h0);
        advance();
        apply(1'b1, 6'b000010, 1'b0, 32'd0, 1'b0);
        check("redir_flush_req", 32'(mem_req_o), 32'd0);
        check("redir_flush_sreq", 32'(if_stall_req_o), 32'd1);
        advance();
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_req("redir_first", 32'h200);
        advance();
        idle(4);
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_present("redir_done", 32'h200, word_at(32'h200));
        advance();

        // Fetch at the top of the address space wraps to zero; low target bits are dropped.
        do_reset();
        apply(1'b1, 6'd0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        check("wrap_redir_req", 32'(mem_req_o), 32'd0);
        advance();
        idle(1);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
            check_req($sformatf("wrap_a%0d", i), 32'hFFFF_FFFC + 32'(i));
            advance();
        end
        idle(1);
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_present("wrap_done", 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC));
        advance();
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_req("wrap_next", 32'h0);
        advance();

        // Reset mid-fetch (with a byte in flight) and reset while presenting.
        do_reset();
        idle(3);
        rst = 1'b0;
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check("midrst_req", 32'(mem_req_o), 32'd0);
        check("midrst_inst", if_inst, 32'h0);
        advance();
        rst = 1'b1;
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_req("midrst_first", 32'h0);
        advance();
        idle(4);
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_present("midrst_done", 32'h0, 32'h0010_0513);
        advance();
        idle(5);
        rst = 1'b0;
        apply(1'b1, 6'b000010, 1'b0, 32'd0, 1'b0);
        check("donerst_pc", if_pc, 32'h0);
        check("donerst_inst", if_inst, 32'h0);
        check("donerst_sreq", 32'(if_stall_req_o), 32'd0);
        advance();
        rst = 1'b1;
        apply(1'b1, 6'd0, 1'b0, 32'd0, 1'b0);
        check_req("donerst_first", 32'h0);
        advance();

        // Randomized grants, stalls and spurious valids against a per-instruction model.
        do_reset();
        m_pc = 32'h0; m_k = 0; due = -1; pres = 1'b0; npres = 0;
        for (int t = 1; t <= 1500; t++) begin
            g     = ($urandom_range(0, 9) < 7);
            st    = 6'($urandom);
            st[1] = ($urandom_range(0, 2) == 0);
            spur  = ($urandom_range(0, 4) == 0);
            apply(g, st, 1'b0, 32'd0, spur);
            if (pres) begin
                check_present("rnd", m_pc, word_at(m_pc));
                if (!st[1]) begin
                    m_pc  = m_pc + 32'd4;
                    m_k   = 0;
                    pres  = 1'b0;
                    npres++;
                end
            end else begin
                check("rnd_bubble", 32'(if_stall_req_o && if_inst == 32'h0 && if_pc == 32'h0), 32'd1);
                if (mem_req_o) begin
                    check("rnd_req_allowed", 32'(m_k < 4), 32'd1);
                    if (m_k < 4) check("rnd_addr", mem_addr_o, m_pc + 32'(m_k));
                    if (g) begin
                        m_k++;
                        if (m_k == 4) due = t + 2;
                    end
                end else begin
                    check("rnd_req_expected", 32'(m_k == 4), 32'd1);
                end
                if (m_k == 4 && t + 1 == due) pres = 1'b1;
            end
            advance();
        end
        check("rnd_progress", 32'(npres >= 50), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
